// File: rtl/bno085_pkg.sv
// rtl/bno085_pkg.sv - BNO085 SHTP report IDs, report lengths and parser state type
package bno085_pkg;

   localparam logic [7:0] RPT_TIMEBASE  = 8'hFB;
   localparam logic [7:0] RPT_ROTV      = 8'h05;
   localparam logic [7:0] RPT_GAME_ROTV = 8'h08;
   localparam logic [7:0] RPT_GYRO_CAL  = 8'h02;

   localparam logic [3:0] LEN_TIMEBASE  = 4'd5;
   localparam logic [3:0] LEN_ROTV      = 4'd14;
   localparam logic [3:0] LEN_GAME_ROTV = 4'd12;
   localparam logic [3:0] LEN_GYRO_CAL  = 4'd10;

   localparam int SHTP_HDR_LEN = 4;

   typedef enum logic [1:0] {HDR, RPT_ID, RPT_BODY, SKIP} parse_state_t;

   // Total report length for a report ID; 0 marks an ID this parser does not know.
   function automatic logic [3:0] report_len(input logic [7:0] id);
      case (id)
         RPT_TIMEBASE:  return LEN_TIMEBASE;
         RPT_ROTV:      return LEN_ROTV;
         RPT_GAME_ROTV: return LEN_GAME_ROTV;
         RPT_GYRO_CAL:  return LEN_GYRO_CAL;
         default:       return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/bno085_report_parser.sv
// rtl/bno085_report_parser.sv - SHTP byte stream parser publishing quaternion and gyro words
module bno085_report_parser
   import bno085_pkg::*;
#(
   parameter logic [7:0] CHANNEL = 8'd3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   input  logic               in_last,
   output logic signed [15:0] quat_w,
   output logic signed [15:0] quat_x,
   output logic signed [15:0] quat_y,
   output logic signed [15:0] quat_z,
   output logic               quat_valid,
   output logic               quat_update,
   output logic signed [15:0] gyro_x,
   output logic signed [15:0] gyro_y,
   output logic signed [15:0] gyro_z,
   output logic               gyro_valid,
   output logic               gyro_update,
   output logic [7:0]         err_count
);

   parse_state_t    state, state_nxt;
   logic [1:0]      hdr_cnt;
   logic [14:0]     len;
   logic [7:0]      chan;
   logic [15:0]     pos, pos_nxt;
   logic [7:0]      rpt_id;
   logic [3:0]      rpt_off, rpt_len, id_len;
   logic [1:0]      word_sel;
   logic [3:0][15:0] stage, stage_nxt;
   logic            last_byte, err_inc, commit_q, commit_g;

   // Staging words for report offsets 4..11; the final byte is merged here so a commit sees it.
   always_comb begin
      stage_nxt = stage;
      word_sel  = rpt_off[2:1] - 2'd2;
      if (in_valid && state == RPT_BODY && rpt_off >= 4'd4 && rpt_off <= 4'd11) begin
         if (rpt_off[0]) stage_nxt[word_sel][15:8] = in_data;
         else            stage_nxt[word_sel][7:0]  = in_data;
      end
   end

   // Next-state, commit and error decisions for the byte presented this cycle.
   always_comb begin
      state_nxt = state;
      err_inc   = 1'b0;
      commit_q  = 1'b0;
      commit_g  = 1'b0;
      pos_nxt   = pos + 16'd1;
      id_len    = report_len(in_data);
      last_byte = (rpt_off == rpt_len - 4'd1);
      if (in_valid) begin
         case (state)
            HDR: begin
               if (hdr_cnt == 2'(SHTP_HDR_LEN - 1))
                  state_nxt = (chan != CHANNEL || len <= 15'(SHTP_HDR_LEN)) ? SKIP : RPT_ID;
            end
            RPT_ID: begin
               if (id_len == 4'd0 || in_last || pos_nxt >= {1'b0, len}) begin
                  err_inc   = 1'b1;
                  state_nxt = SKIP;
               end else begin
                  state_nxt = RPT_BODY;
               end
            end
            RPT_BODY: begin
               if (last_byte) begin
                  commit_q  = (rpt_id == RPT_ROTV) || (rpt_id == RPT_GAME_ROTV);
                  commit_g  = (rpt_id == RPT_GYRO_CAL);
                  state_nxt = (pos_nxt < {1'b0, len}) ? RPT_ID : SKIP;
               end else if (in_last || pos_nxt >= {1'b0, len}) begin
                  err_inc   = 1'b1;
                  state_nxt = SKIP;
               end
            end
            default: state_nxt = SKIP;
         endcase
         if (in_last) state_nxt = HDR;
      end
   end

   // Parser registers, staged data and the registered output words.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HDR;
         hdr_cnt     <= 2'd0;
         len         <= 15'd0;
         chan        <= 8'd0;
         pos         <= 16'd0;
         rpt_id      <= 8'd0;
         rpt_off     <= 4'd0;
         rpt_len     <= 4'd0;
         stage       <= '0;
         quat_w      <= '0;
         quat_x      <= '0;
         quat_y      <= '0;
         quat_z      <= '0;
         quat_valid  <= 1'b0;
         quat_update <= 1'b0;
         gyro_x      <= '0;
         gyro_y      <= '0;
         gyro_z      <= '0;
         gyro_valid  <= 1'b0;
         gyro_update <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         quat_update <= commit_q;
         gyro_update <= commit_g;
         if (commit_q) begin
            quat_x     <= stage_nxt[0];
            quat_y     <= stage_nxt[1];
            quat_z     <= stage_nxt[2];
            quat_w     <= stage_nxt[3];
            quat_valid <= 1'b1;
         end
         if (commit_g) begin
            gyro_x     <= stage_nxt[0];
            gyro_y     <= stage_nxt[1];
            gyro_z     <= stage_nxt[2];
            gyro_valid <= 1'b1;
         end
         if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (in_valid) begin
            state <= state_nxt;
            stage <= stage_nxt;
            pos   <= in_last ? 16'd0 : pos_nxt;
            if (state == HDR) begin
               hdr_cnt <= hdr_cnt + 2'd1;
               case (hdr_cnt)
                  2'd0:    len[7:0]  <= in_data;
                  2'd1:    len[14:8] <= in_data[6:0];
                  2'd2:    chan      <= in_data;
                  default: ;
               endcase
            end
            if (state == RPT_ID) begin
               rpt_id  <= in_data;
               rpt_len <= id_len;
               rpt_off <= 4'd1;
            end
            if (state == RPT_BODY) rpt_off <= rpt_off + 4'd1;
            if (in_last) hdr_cnt <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_bno085_report_parser.sv
// tb/tb_bno085_report_parser.sv - self-checking bench for bno085_report_parser
module tb_bno085_report_parser;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic in_last = 1'b0;
   logic signed [15:0] quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z;
   logic quat_valid, quat_update, gyro_valid, gyro_update;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   bno085_report_parser #(.CHANNEL(8'd3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
      .quat_valid(quat_valid), .quat_update(quat_update),
      .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
      .gyro_valid(gyro_valid), .gyro_update(gyro_update),
      .err_count(err_count)
   );

   typedef struct {
      bit          is_quat;
      logic [15:0] a, b, c, d;
   } commit_t;

   commit_t obs_q[$];
   commit_t exp_q[$];
   logic [15:0] e_qw, e_qx, e_qy, e_qz, e_gx, e_gy, e_gz;
   bit e_qv, e_gv;
   int e_err;
   int checks = 0;
   int failures = 0;

   // Record every commit the DUT announces, in order.
   always @(negedge clk) begin
      if (!rst && quat_update) obs_q.push_back('{1'b1, quat_w, quat_x, quat_y, quat_z});
      if (!rst && gyro_update) obs_q.push_back('{1'b0, gyro_x, gyro_y, gyro_z, 16'h0});
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e_qw = 0; e_qx = 0; e_qy = 0; e_qz = 0; e_gx = 0; e_gy = 0; e_gz = 0;
      e_qv = 0; e_gv = 0; e_err = 0;
      exp_q.delete();
   endtask

   function automatic logic [15:0] w16(input logic [7:0] p[$], input int i);
      return {p[i+1], p[i]};
   endfunction

   // Reference: walk the packet report by report with plain index arithmetic.
   task automatic model_pkt(input logic [7:0] p[$]);
      int n, len, k, rl;
      n = p.size();
      if (n < 4) return;
      len = int'({p[1][6:0], p[0]});
      if (p[2] != 8'd3 || len <= 4) return;
      k = 4;
      while (k < len && k < n) begin
         case (p[k])
            8'hFB:   rl = 5;
            8'h05:   rl = 14;
            8'h08:   rl = 12;
            8'h02:   rl = 10;
            default: rl = 0;
         endcase
         if (rl == 0 || k + rl > len || k + rl > n) begin
            if (e_err < 255) e_err++;
            break;
         end
         if (p[k] == 8'h05 || p[k] == 8'h08) begin
            e_qx = w16(p, k+4); e_qy = w16(p, k+6); e_qz = w16(p, k+8); e_qw = w16(p, k+10);
            e_qv = 1;
            exp_q.push_back('{1'b1, e_qw, e_qx, e_qy, e_qz});
         end else if (p[k] == 8'h02) begin
            e_gx = w16(p, k+4); e_gy = w16(p, k+6); e_gz = w16(p, k+8);
            e_gv = 1;
            exp_q.push_back('{1'b0, e_gx, e_gy, e_gz, 16'h0});
         end
         k += rl;
      end
   endtask

   task automatic send_bytes(input logic [7:0] p[$], input int nbytes, input int maxgap);
      for (int i = 0; i < nbytes; i++) begin
         repeat ($urandom_range(0, maxgap)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = p[i];
         in_last  = (i == p.size() - 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_qw"}, quat_w, e_qw);
      check({tag, "_qx"}, quat_x, e_qx);
      check({tag, "_qy"}, quat_y, e_qy);
      check({tag, "_qz"}, quat_z, e_qz);
      check({tag, "_gx"}, gyro_x, e_gx);
      check({tag, "_gy"}, gyro_y, e_gy);
      check({tag, "_gz"}, gyro_z, e_gz);
      check({tag, "_qv"}, quat_valid, e_qv);
      check({tag, "_gv"}, gyro_valid, e_gv);
      check({tag, "_qupd_idle"}, quat_update, 1'b0);
      check({tag, "_gupd_idle"}, gyro_update, 1'b0);
      check({tag, "_err"}, err_count, 16'(e_err));
   endtask

   task automatic compare_commits(input string tag);
      commit_t o, e;
      check({tag, "_ncommit"}, 16'(obs_q.size()), 16'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_kind"}, o.is_quat, e.is_quat);
         check({tag, "_a"}, o.a, e.a);
         check({tag, "_b"}, o.b, e.b);
         check({tag, "_c"}, o.c, e.c);
         check({tag, "_d"}, o.d, e.d);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic run_pkt(input string tag, input logic [7:0] p[$], input int maxgap);
      model_pkt(p);
      send_bytes(p, p.size(), maxgap);
      repeat (2) @(posedge clk);
      #1;
      compare_commits(tag);
      check_state(tag);
   endtask

   task automatic gen_random(output logic [7:0] p[$]);
      int nrep, kind, rl, total, len;
      logic [7:0] id;
      p = '{8'h00, 8'h00, 8'h00, 8'h00};
      nrep = $urandom_range(1, 3);
      for (int r = 0; r < nrep; r++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1:    begin id = 8'hFB; rl = 5;  end
            2, 3, 9: begin id = 8'h05; rl = 14; end
            4, 5:    begin id = 8'h08; rl = 12; end
            6, 7:    begin id = 8'h02; rl = 10; end
            default: begin id = 8'h11; rl = 5;  end
         endcase
         p.push_back(id);
         for (int b = 1; b < rl; b++) p.push_back(8'($urandom));
      end
      total = p.size();
      len = total;
      if ($urandom_range(0, 5) == 0) len = total - $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 6)) void'(p.pop_back());
      p[0] = len[7:0];
      p[1] = {1'($urandom), len[14:8]};
      p[2] = ($urandom_range(0, 7) == 0) ? 8'd2 : 8'd3;
      p[3] = 8'($urandom);
   endtask

   logic [7:0] pkt[$];
   logic [7:0] t1[$];

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_state("reset");

      t1 = '{8'h17, 8'h00, 8'h03, 8'h00, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h05, 8'h01, 8'h00, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A,
             8'h00, 8'h40, 8'h00, 8'h00};
      @(posedge clk); #1;
      run_pkt("rotv", t1, 0);
      check("rotv_w_const", quat_w, 16'h4000);
      check("rotv_x_const", quat_x, 16'h1234);
      check("rotv_y_const", quat_y, 16'h5678);
      check("rotv_z_const", quat_z, 16'h9ABC);

      pkt = '{8'h1A, 8'h00, 8'h03, 8'h07,
              8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h80,
              8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
      run_pkt("two_rpt", pkt, 0);
      check("gyro_x_const", gyro_x, 16'hFFFF);
      check("gyro_y_const", gyro_y, 16'h0001);
      check("gyro_z_const", gyro_z, 16'h8000);

      pkt = '{8'h12, 8'h00, 8'h03, 8'h00, 8'h05, 8'h01, 8'h00, 8'h00, 8'h99, 8'h99,
              8'h88, 8'h88, 8'h77};
      run_pkt("trunc", pkt, 0);
      check("trunc_err_const", err_count, 16'd1);
      run_pkt("after_trunc", t1, 0);

      pkt = '{8'h09, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      run_pkt("unknown_id", pkt, 0);
      pkt = '{8'h12, 8'h00, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02,
              8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00};
      run_pkt("foreign_ch", pkt, 0);
      check("unk_err_const", err_count, 16'd2);

      run_pkt("gapped_rotv", t1, 5);
      check("gapped_w_const", quat_w, 16'h4000);

      for (int i = 0; i < 40; i++) begin
         gen_random(pkt);
         run_pkt($sformatf("rand%0d", i), pkt, (i % 2 == 0) ? 0 : 5);
      end

      pkt = '{8'h05, 8'h00, 8'h03, 8'h00, 8'h11};
      for (int i = 0; i < 260; i++) begin
         model_pkt(pkt);
         send_bytes(pkt, pkt.size(), 0);
      end
      repeat (2) @(posedge clk);
      #1;
      check("sat_err", err_count, 16'h00FF);
      check_state("sat");

      pkt = '{8'h12, 8'h00, 8'h03, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0B,
              8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h20, 8'h00, 8'h00};
      send_bytes(pkt, 10, 0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      obs_q.delete();
      check_state("in_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      run_pkt("post_reset", pkt, 2);
      check("post_reset_w", quat_w, 16'h2010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bno085_report_parser.md
# bno085_report_parser

Streaming parser between the BNO085 SHTP byte transport and the MCU SPI slave. It consumes the raw bytes of each SHTP packet, decodes channel-3 input reports (rotation vector, game rotation vector, calibrated gyroscope) and publishes signed 16-bit quaternion and gyro words with valid flags. These outputs drive the slave's `quat1_*`, `gyro1_*`, `quat1_valid` and `gyro1_valid` inputs directly. All updates are atomic per report, so a four-word quaternion is never half old and half new.

## Interface
- `CHANNEL`, default 3: SHTP channel carrying input reports; all other channels are skipped.
- `clk`  in  1: FPGA system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_data` holds a packet byte this cycle. There is no backpressure; the parser accepts every byte.
- `in_data`  in  8: packet byte, starting with SHTP header byte 0.
- `in_last`  in  1: qualified by `in_valid`; marks the final byte of the packet as framed by the transport.
- `quat_w`, `quat_x`, `quat_y`, `quat_z`  out  16 signed each: last committed quaternion. `w` = real, `x` = i, `y` = j, `z` = k.
- `quat_valid`  out  1: sticky; set at the first quaternion commit.
- `quat_update`  out  1: one-cycle pulse on each quaternion commit.
- `gyro_x`, `gyro_y`, `gyro_z`  out  16 signed each: last committed gyro.
- `gyro_valid`  out  1: sticky; set at the first gyro commit.
- `gyro_update`  out  1: one-cycle pulse on each gyro commit.
- `err_count`  out  8: saturating count of truncated reports and unknown report IDs.

## Operation
- **Header.** Header bytes 0–1 form the little-endian length; bit 15 (continuation) is masked off. Header byte 2 is the channel. Header byte 3 is the sequence number and is ignored.
- `len` counts header bytes. After the header, the byte counter `pos` runs to `len`.
- If the channel is not `CHANNEL`, or `len` ≤ 4, go to SKIP.
- **Report dispatch.** Each report's first byte is its ID, which selects its total length:
  - 0xFB timebase: 5 bytes, discarded.
  - 0x05 rotation vector: 14 bytes.
  - 0x08 game rotation vector: 12 bytes.
  - 0x02 calibrated gyro: 10 bytes.
  - Any other ID: `err_count` +1, then SKIP for the rest of the packet.
- **Field layout.** Quaternion reports place i, j, k, real as little-endian words at report offsets 4–11. Gyro reports place x, y, z at offsets 4–9. All other bytes (sequence, status, delay, accuracy) are ignored.
- **Staging and commit.** Fields are assembled in staging registers. Outputs are written only when the report's final byte is accepted, and all words of that report are written in the same cycle.
- **States:**
  - HDR: accepts 4 header bytes. → RPT_ID, or → SKIP.
  - RPT_ID: accepts the ID byte. → RPT_BODY, or → SKIP (unknown ID).
  - RPT_BODY: count remaining report bytes; on the last byte, commit. → RPT_ID if `pos` < `len`, otherwise → SKIP.
  - SKIP: discard bytes until `in_last`.
- Any byte with `in_last` returns the parser to HDR on the next cycle, whatever the current state.
- **Boundaries:**
  - `in_last` before the header completes: packet dropped, no error counted.
  - `in_last` mid-report, or `len` reached mid-report: staged data discarded, `err_count` +1, no commit.
  - `in_last` on a report's final byte: commit, then HDR.
  - `in_valid` low: all state holds; gaps of any length are legal.
  - `err_count` saturates at 0xFF.

## Timing
- Reset values:
  - all data outputs 0;
  - `quat_valid`, `gyro_valid`, `quat_update`, `gyro_update` all 0;
  - `err_count` 0;
  - state HDR.
- Reset mid-packet abandons the packet. The following bytes are parsed as a new header.
- Commit latency: outputs and the update pulse are visible in the cycle after the clock edge that accepts the final report byte. That is one register stage; there is no combinational path from `in_data` to any output.
- Throughput: one byte per cycle. Back-to-back packets are legal; a header byte may arrive in the cycle immediately after `in_last`.
- Outputs hold their values between commits and are never cleared except by `rst`.

## Structure
- Package `bno085_pkg` holds:
  - report ID constants (`RPT_TIMEBASE` 0xFB, `RPT_ROTV` 0x05, `RPT_GAME_ROTV` 0x08, `RPT_GYRO_CAL` 0x02);
  - report length constants (5, 14, 12, 10);
  - `SHTP_HDR_LEN` 4;
  - the state enum `parse_state_t` {HDR, RPT_ID, RPT_BODY, SKIP}.
- The block is a single module. No sub-module is warranted, because the little-endian assembly is a two-line shift.

## Test plan
- **Rotation vector after timebase.**
  - Stimulus: packet `17 00 03 00 | FB 00 00 00 00 | 05 01 00 00 34 12 78 56 BC 9A 00 40 00 00`, `in_last` on the final byte.
  - Response: `quat_w`=0x4000, `x`=0x1234, `y`=0x5678, `z`=0x9ABC (−25924); `quat_update` pulses once; `quat_valid`=1; `err_count`=0.
- **Two reports in one packet.**
  - Stimulus: gyro `02 00 00 00 FF FF 01 00 00 80` followed by a game rotation vector in the same packet.
  - Response: gyro (−1, 1, −32768) and the quaternion both commit, with the update pulses in separate cycles.
- **Truncated report.**
  - Stimulus: quaternion report with `in_last` on report byte 8.
  - Response: outputs unchanged, `err_count` +1, the next packet parses normally.
- **Unknown ID and foreign channel.**
  - Stimulus: a report with ID 0x11, then a channel-2 packet.
  - Response: `err_count` +1 for the unknown ID; no commit from either packet.
- **Gapped input.**
  - Stimulus: `in_valid` toggled with random gaps of 0–5 cycles across a valid packet.
  - Response: results identical to the gap-free case.
- **Mid-packet reset.**
  - Stimulus: `rst` asserted at report byte 6, then a full valid packet.
  - Response: all outputs 0 during reset; the new packet commits correctly.
